// File: rtl/serial_word_feeder_pkg.sv
// serial_word_feeder_pkg: shared types and frame sizing for serial_word_feeder.
// SERIAL_WORD_FEEDER_PARITY_EN adds one even-parity bit to every frame.
package serial_word_feeder_pkg;

    typedef enum logic {IDLE, SHIFT} state_t;

    function automatic int frame_len(input int width);
`ifdef SERIAL_WORD_FEEDER_PARITY_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

    function automatic int cnt_w(input int width);
        return $clog2(frame_len(width));
    endfunction

    localparam int FRAME_LEN = frame_len(8);
    localparam int CNT_W     = cnt_w(8);

endpackage

// File: rtl/serial_word_feeder_frame_bit_counter.sv
// frame_bit_counter: loadable up-counter over 0..N-1 with terminal-count flag.
module frame_bit_counter #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);
    logic [W-1:0] cnt_q, cnt_d;

    assign tc_o  = cnt_q == W'(N - 1);
    assign cnt_o = cnt_q;

    // Wraps to 0 after the terminal bit so IDLE always starts from a clean count.
    always_comb cnt_d = load_i ? '0 : !en_i ? cnt_q : tc_o ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
endmodule

// File: rtl/serial_word_feeder.sv
// serial_word_feeder: valid/ready word to MSB-first serial stream, back-to-back frames.
// SERIAL_WORD_FEEDER_PARITY_EN appends an even-parity bit after the LSB.
module serial_word_feeder
    import serial_word_feeder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_last
);
    localparam int FL = frame_len(WIDTH);
    localparam int CW = cnt_w(WIDTH);

    state_t           state_q;
    logic [WIDTH-2:0] sr_q;
    logic             sout_q, sout_valid_q;
    logic [CW-1:0]    cnt;
    logic             tc, accept, par_bit, next_bit;

    assign din_ready  = !rst && (state_q == IDLE || tc);
    assign accept     = din_valid && din_ready;
    assign sout       = sout_q;
    assign sout_valid = sout_valid_q;
    assign sout_last  = sout_valid_q && tc;

`ifdef SERIAL_WORD_FEEDER_PARITY_EN
    logic parity_q;
    always_ff @(posedge clk or posedge rst)
        if (rst)         parity_q <= 1'b0;
        else if (accept) parity_q <= ^din;
    assign par_bit = parity_q;
`else
    assign par_bit = 1'b0;
`endif

    // Without parity the LSB is terminal, so the par_bit branch is never taken.
    assign next_bit = (cnt == CW'(WIDTH - 1)) ? par_bit : sr_q[WIDTH-2];

    frame_bit_counter #(.N(FL), .W(CW)) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .load_i (accept),
        .en_i   (state_q == SHIFT),
        .cnt_o  (cnt),
        .tc_o   (tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            sr_q         <= '0;
            sout_q       <= 1'b0;
            sout_valid_q <= 1'b0;
        end else if (accept) begin
            state_q      <= SHIFT;
            sr_q         <= din[WIDTH-2:0];
            sout_q       <= din[WIDTH-1];
            sout_valid_q <= 1'b1;
        end else if (state_q == SHIFT) begin
            if (tc) begin
                state_q      <= IDLE;
                sout_q       <= 1'b0;
                sout_valid_q <= 1'b0;
            end else begin
                sout_q <= next_bit;
                sr_q   <= sr_q << 1;
            end
        end
    end
endmodule
